// File: rtl/game_ctrl.sv
// Frame-stepped game state for a flappy-bird style game: bird physics, pipe scroll, scoring.
// Optional define GAME_CTRL_RAND_GAP_EN builds an 8-bit LFSR that randomises the gap on each pipe wrap.
module game_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int FLOOR_Y    = 440,
    parameter int BIRD_Y0    = 240,
    parameter int BIRD_X     = 160,
    parameter int PIPE_W     = 64,
    parameter int PIPE_SPEED = 2,
    parameter int GRAVITY    = 1,
    parameter int FLAP_VEL   = -8,
    parameter int VMAX       = 8,
    parameter int GAP_Y0     = 200,
    parameter int GAP_MIN    = 80
) (
    input  logic        pix_clk,
    input  logic        pix_rstn,
    input  logic        btn_press,
    input  logic        new_frame,
    input  logic        collide,
    output logic [1:0]  game_state,
    output logic [15:0] bird_y,
    output logic [15:0] pipe_x,
    output logic [15:0] gap_y,
    output logic [15:0] score,
    output logic        upd_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic signed [8:0]  GRAV9     = 9'(GRAVITY);
    localparam logic signed [8:0]  VMAX9     = 9'(VMAX);
    localparam logic signed [7:0]  FLAP8     = 8'(FLAP_VEL);
    localparam logic signed [16:0] FLOOR17   = 17'(FLOOR_Y);
    localparam logic [15:0]        FLOOR16   = 16'(FLOOR_Y);
    localparam logic [15:0]        BIRD_Y016 = 16'(BIRD_Y0);
    localparam logic [15:0]        BIRD_X16  = 16'(BIRD_X);
    localparam logic [15:0]        SPEED16   = 16'(PIPE_SPEED);
    localparam logic [15:0]        SCREEN16  = 16'(SCREEN_W);
    localparam logic [15:0]        WRAP16    = 16'(SCREEN_W + PIPE_W);
    localparam logic [15:0]        GAP_Y016  = 16'(GAP_Y0);

    state_t             state_q, state_d;
    logic [15:0]        bird_y_q, bird_y_d;
    logic [15:0]        pipe_x_q, pipe_x_d;
    logic [15:0]        gap_y_q, gap_y_d;
    logic [15:0]        score_q, score_d;
    logic signed [7:0]  vel_q, vel_d;
    logic               flap_q, flap_d;
    logic               upd_q, upd_d;

    logic               flap_eff;
    logic               do_play;
    logic signed [8:0]  vel_inc;
    logic signed [7:0]  vel_new;
    logic signed [16:0] sum;
    logic [15:0]        gap_wrap;

`ifdef GAME_CTRL_RAND_GAP_EN
    localparam logic [15:0] GAP_MIN16 = 16'(GAP_MIN);
    logic [7:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign gap_wrap = GAP_MIN16 + {8'd0, lfsr_q};
`else
    assign gap_wrap = GAP_Y016;
`endif

    // A press arriving with the frame pulse belongs to that frame's update.
    assign flap_eff = flap_q | btn_press;

    always_comb begin
        state_d  = state_q;
        bird_y_d = bird_y_q;
        pipe_x_d = pipe_x_q;
        gap_y_d  = gap_y_q;
        score_d  = score_q;
        vel_d    = vel_q;
        flap_d   = flap_eff;
        upd_d    = 1'b0;
        do_play  = 1'b0;
        vel_inc  = {vel_q[7], vel_q} + GRAV9;
        vel_new  = flap_eff ? FLAP8 : ((vel_inc > VMAX9) ? VMAX9[7:0] : vel_inc[7:0]);
        sum      = {1'b0, bird_y_q} + {{9{vel_new[7]}}, vel_new};

        if (new_frame) begin
            upd_d  = 1'b1;
            flap_d = 1'b0;
            case (state_q)
                IDLE: if (flap_eff) do_play = 1'b1;
                PLAY: begin
                    if (collide) state_d = DEAD;
                    else         do_play = 1'b1;
                end
                DEAD: begin
                    if (flap_eff) begin
                        state_d  = IDLE;
                        bird_y_d = BIRD_Y016;
                        vel_d    = 8'sd0;
                        pipe_x_d = SCREEN16;
                        gap_y_d  = GAP_Y016;
                        score_d  = 16'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_play) begin
            state_d = PLAY;
            vel_d   = vel_new;
            if (sum[16]) begin
                bird_y_d = 16'd0;
                vel_d    = 8'sd0;
            end else if (sum >= FLOOR17) begin
                bird_y_d = FLOOR16;
                state_d  = DEAD;
            end else begin
                bird_y_d = sum[15:0];
            end

            if (pipe_x_q < SPEED16) begin
                pipe_x_d = WRAP16;
                gap_y_d  = gap_wrap;
            end else begin
                pipe_x_d = pipe_x_q - SPEED16;
                if (pipe_x_q >= BIRD_X16 && pipe_x_d < BIRD_X16 && score_q != 16'hFFFF)
                    score_d = score_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pix_clk) begin
        if (!pix_rstn) begin
            state_q  <= IDLE;
            bird_y_q <= BIRD_Y016;
            vel_q    <= 8'sd0;
            pipe_x_q <= SCREEN16;
            gap_y_q  <= GAP_Y016;
            score_q  <= 16'd0;
            flap_q   <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bird_y_q <= bird_y_d;
            vel_q    <= vel_d;
            pipe_x_q <= pipe_x_d;
            gap_y_q  <= gap_y_d;
            score_q  <= score_d;
            flap_q   <= flap_d;
            upd_q    <= upd_d;
        end
    end

    assign game_state = state_q;
    assign bird_y     = bird_y_q;
    assign pipe_x     = pipe_x_q;
    assign gap_y      = gap_y_q;
    assign score      = score_q;
    assign upd_done   = upd_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: hand-computed trajectories for flap, ceiling, floor, scoring, wrap, collide, reset.
module tb_game_ctrl;

    logic        pix_clk = 1'b0;
    logic        pix_rstn;
    logic        btn_press;
    logic        new_frame;
    logic        collide;
    logic [1:0]  game_state;
    logic [15:0] bird_y;
    logic [15:0] pipe_x;
    logic [15:0] gap_y;
    logic [15:0] score;
    logic        upd_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    always #5 pix_clk = ~pix_clk;

    game_ctrl dut (
        .pix_clk    (pix_clk),
        .pix_rstn   (pix_rstn),
        .btn_press  (btn_press),
        .new_frame  (new_frame),
        .collide    (collide),
        .game_state (game_state),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .score      (score),
        .upd_done   (upd_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int by, input int px, input int sc);
        check({tag, ".state"}, {30'd0, game_state}, st);
        check({tag, ".bird_y"}, {16'd0, bird_y}, by);
        check({tag, ".pipe_x"}, {16'd0, pipe_x}, px);
        check({tag, ".score"}, {16'd0, score}, sc);
    endtask

    // One frame pulse with optional coincident press/collide; returns on the negedge after the update.
    task automatic frame(input logic press, input logic coll);
        @(negedge pix_clk);
        new_frame = 1'b1;
        btn_press = press;
        collide   = coll;
        @(negedge pix_clk);
        new_frame = 1'b0;
        btn_press = 1'b0;
        collide   = 1'b0;
    endtask

    task automatic frames(input int n, input logic press);
        for (int i = 0; i < n; i++) frame(press, 1'b0);
    endtask

    initial begin
        pix_rstn  = 1'b0;
        btn_press = 1'b0;
        new_frame = 1'b0;
        collide   = 1'b0;
        repeat (3) @(negedge pix_clk);
        check_all("reset", 0, 240, 640, 0);
        check("reset.gap_y", {16'd0, gap_y}, 200);
        check("reset.upd_done", {31'd0, upd_done}, 0);
        pix_rstn = 1'b1;

        frame(0, 0);
        check_all("idle_hold", 0, 240, 640, 0);

        // Two separate presses before the frame count as a single flap.
        @(negedge pix_clk) btn_press = 1'b1;
        @(negedge pix_clk) btn_press = 1'b0;
        @(negedge pix_clk) btn_press = 1'b1;
        @(negedge pix_clk) btn_press = 1'b0;
        check("no_frame.state", {30'd0, game_state}, 0);
        frame(0, 0);
        check_all("start", 1, 232, 638, 0);
        check("start.upd_done", {31'd0, upd_done}, 1);
        @(negedge pix_clk);
        check("start.upd_done_low", {31'd0, upd_done}, 0);

        frame(0, 0);
        check("fall1.bird_y", {16'd0, bird_y}, 225);
        frame(0, 0);
        check_all("fall2", 1, 219, 634, 0);
        frames(4, 0);
        check("fall6.bird_y", {16'd0, bird_y}, 205);
        frames(25, 1);
        check_all("flaps", 1, 5, 576, 0);
        frame(1, 0);
        check_all("ceiling", 1, 0, 574, 0);
        frame(0, 0);
        check("ceiling_vel0.bird_y", {16'd0, bird_y}, 1);
        frames(7, 0);
        check("accel.bird_y", {16'd0, bird_y}, 36);
        frame(0, 0);
        check("vmax1.bird_y", {16'd0, bird_y}, 44);
        frame(0, 0);
        check("vmax2.bird_y", {16'd0, bird_y}, 52);
        frames(48, 0);
        check_all("near_floor", 1, 436, 458, 0);
        frame(0, 0);
        check_all("floor", 2, 440, 456, 0);
        frame(0, 0);
        check_all("dead_frozen", 2, 440, 456, 0);
        frame(0, 1);
        check_all("dead_collide", 2, 440, 456, 0);

        frame(1, 0);
        check_all("restart", 0, 240, 640, 0);
        frame(0, 1);
        check_all("idle_collide", 0, 240, 640, 0);

        // Flap every frame keeps the bird pinned at the ceiling while the pipe scrolls.
        frames(239, 1);
        check_all("pre_cross", 1, 0, 162, 0);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        for (int i = 0; i < 2; i++) begin
            frame(1, 0);
            check($sformatf("cross%0d.score", i), {16'd0, score}, {16'd0, exp_q.pop_front()});
        end
        check("cross.pipe_x", {16'd0, pipe_x}, 158);
        frames(78, 1);
        check_all("pipe_low", 1, 0, 2, 1);
        frame(1, 0);
        check("pipe_zero.pipe_x", {16'd0, pipe_x}, 0);
        frame(1, 0);
        check_all("wrap", 1, 0, 704, 1);
        check("wrap.gap_y", {16'd0, gap_y}, 200);

        frame(1, 1);
        check_all("collide_flap", 2, 0, 704, 1);
        frame(1, 0);
        check_all("restart2", 0, 240, 640, 0);
        frame(1, 0);
        check_all("replay", 1, 232, 638, 0);

        @(negedge pix_clk);
        pix_rstn  = 1'b0;
        new_frame = 1'b1;
        btn_press = 1'b1;
        @(negedge pix_clk);
        check_all("mid_reset", 0, 240, 640, 0);
        check("mid_reset.upd_done", {31'd0, upd_done}, 0);
        new_frame = 1'b0;
        btn_press = 1'b0;
        pix_rstn  = 1'b1;
        frame(0, 0);
        check("post_reset.state", {30'd0, game_state}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
